// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame FSM encoding, default baud divisor and byte type.
// Imported by the transmitter and by the matching receiver.
package uart_tx_pkg;

    localparam int unsigned BAUD_W    = 15;
    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS);

    // 868 clocks per bit: 115200 bps from a 100 MHz clock
    localparam logic [BAUD_W-1:0] BAUD_DIV_DEFAULT = 15'd867;

    typedef logic [DATA_BITS-1:0] uart_byte_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream valid/ready handshake between a byte source and the transmit buffer.
interface uart_tx_if;
    import uart_tx_pkg::*;

    uart_byte_t data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock transmit byte buffer; push side is a valid/ready stream, ready is ~full.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_n,
    uart_tx_if.slave      push,
    input  logic          pop_i,
    output uart_byte_t    rd_data_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    uart_byte_t    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_push;
    logic          w_pop;

    assign w_full     = (r_count == CW'(DEPTH));
    assign empty_o    = (r_count == '0);
    assign push.ready = ~w_full;
    assign w_push     = push.valid & ~w_full;
    assign w_pop      = pop_i & ~empty_o;
    assign count_o    = r_count;
    assign rd_data_o  = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= push.data;
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8 data bits MSB-first, no parity, 1 or 2 stop bits.
// The line register follows the FSM state by one cycle, so a bit lasts exactly BAUD_DIV+1 clocks.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter  logic [BAUD_W-1:0] BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter  int unsigned       FIFO_DEPTH = 16,
    parameter  int unsigned       STOP_BITS  = 1,
    localparam int unsigned       CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  uart_byte_t       tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic             uart_tx_o,
    output logic             tx_busy_o,
    output logic             uart_tx_done,
    output logic [CNT_W-1:0] fifo_count_o
);

    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    uart_tx_if u_push_if ();

    uart_state_e          r_state;
    uart_state_e          w_state_nxt;
    logic [BAUD_W-1:0]    r_baud_cnt;
    logic [BAUD_W-1:0]    w_baud_nxt;
    logic [BIT_CNT_W-1:0] r_bit_cnt;
    logic [BIT_CNT_W-1:0] w_bit_nxt;
    logic                 r_stop_cnt;
    logic                 w_stop_nxt;
    uart_byte_t           r_shift;
    uart_byte_t           w_shift_nxt;
    logic                 r_tx;
    logic                 w_tx_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_busy;
    logic                 w_tick;
    logic                 w_pop;
    logic                 w_empty;
    uart_byte_t           w_rd_data;

    assign u_push_if.data  = tx_data_i;
    assign u_push_if.valid = tx_valid_i;
    assign tx_ready_o      = u_push_if.ready;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n     (rst_n),
        .push      (u_push_if),
        .pop_i     (w_pop),
        .rd_data_o (w_rd_data),
        .empty_o   (w_empty),
        .count_o   (fifo_count_o)
    );

    assign w_tick = (r_baud_cnt == BAUD_DIV);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_stop_cnt <= w_stop_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE) | ~w_empty;
        end
    end

    // Frame sequencing; a new byte is popped from IDLE or straight out of the last stop tick
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_stop_nxt  = r_stop_cnt;
        w_shift_nxt = r_shift;
        w_done_nxt  = 1'b0;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;

        if (r_state != ST_IDLE) begin
            w_baud_nxt = w_tick ? '0 : r_baud_cnt + BAUD_W'(1);
        end

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = ST_START;
                    w_pop       = 1'b1;
                    w_shift_nxt = w_rd_data;
                    w_baud_nxt  = '0;
                end
            end
            ST_START: begin
                w_tx_nxt = 1'b0;
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = '0;
                end
            end
            ST_DATA: begin
                w_tx_nxt = r_shift[DATA_BITS-1];
                if (w_tick) begin
                    w_shift_nxt = {r_shift[DATA_BITS-2:0], 1'b0};
                    w_bit_nxt   = r_bit_cnt + BIT_CNT_W'(1);
                    if (r_bit_cnt == BIT_CNT_W'(DATA_BITS - 1)) begin
                        w_state_nxt = ST_STOP;
                        w_stop_nxt  = 1'b0;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_stop_cnt == STOP_LAST) begin
                        w_done_nxt = 1'b1;
                        if (!w_empty) begin
                            w_state_nxt = ST_START;
                            w_pop       = 1'b1;
                            w_shift_nxt = w_rd_data;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else begin
                        w_stop_nxt = ~r_stop_cnt;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign uart_tx_o    = r_tx;
    assign tx_busy_o    = r_busy;
    assign uart_tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, line monitors decode and compare frames.
`timescale 1ns/1ps
module tb_uart_tx;
    import uart_tx_pkg::*;

    localparam int BIT   = 868;
    localparam int FRM1  = 10 * BIT;
    localparam int FRM2  = 11 * BIT;
    localparam int CW    = 5;
    localparam int GUARD = 20000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n0, rst_n1;
    logic          line0, busy0, done0, line1, busy1, done1;
    logic [CW-1:0] cnt0, cnt1;

    uart_tx_if u_if0 ();
    uart_tx_if u_if1 ();

    uart_tx #(.BAUD_DIV(15'd867), .FIFO_DEPTH(16), .STOP_BITS(1)) u_dut0 (
        .clk_i(clk), .rst_n(rst_n0), .tx_data_i(u_if0.data), .tx_valid_i(u_if0.valid),
        .tx_ready_o(u_if0.ready), .uart_tx_o(line0), .tx_busy_o(busy0),
        .uart_tx_done(done0), .fifo_count_o(cnt0));

    uart_tx #(.BAUD_DIV(15'd867), .FIFO_DEPTH(16), .STOP_BITS(2)) u_dut1 (
        .clk_i(clk), .rst_n(rst_n1), .tx_data_i(u_if1.data), .tx_valid_i(u_if1.valid),
        .tx_ready_o(u_if1.ready), .uart_tx_o(line1), .tx_busy_o(busy1),
        .uart_tx_done(done1), .fifo_count_o(cnt1));

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         starts0 [$];
    int         starts1 [$];

    bit         mon_act  [2] = '{1'b0, 1'b0};
    logic       mon_prev [2] = '{1'b1, 1'b1};
    int         mon_off  [2] = '{0, 0};
    logic [7:0] mon_exp  [2];
    logic [7:0] mon_got  [2];
    bit         mon_bad  [2];
    bit         mon_dbad [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[3'(8 - k)];
        return 1'b1;
    endfunction

    // Serial-line monitor: finds start bits, checks every bit edge, decodes mid-bit, checks done timing
    task automatic mon_step(input int id, input logic line, input logic done, input int sb);
        int flen;
        int k;
        int r;
        flen = (9 + sb) * BIT;
        if (!mon_act[id]) begin
            if (mon_prev[id] === 1'b1 && line === 1'b0) begin
                mon_act[id]  = 1'b1;
                mon_off[id]  = 0;
                mon_bad[id]  = 1'b0;
                mon_dbad[id] = 1'b0;
                mon_got[id]  = 8'h00;
                if (id == 0) begin
                    starts0.push_back(cyc);
                    if (q0.size() > 0) mon_exp[id] = q0.pop_front();
                    else begin chk("unexpected_frame0", 32'(1), 32'(0)); mon_exp[id] = 8'h00; end
                end else begin
                    starts1.push_back(cyc);
                    if (q1.size() > 0) mon_exp[id] = q1.pop_front();
                    else begin chk("unexpected_frame1", 32'(1), 32'(0)); mon_exp[id] = 8'h00; end
                end
            end else if (done !== 1'b0) begin
                nchk++;
                nerr++;
                $display("FAIL done_outside_frame%0d: got %b, expected 0 (cycle %0d)", id, done, cyc);
            end
        end
        if (mon_act[id]) begin
            k = mon_off[id] / BIT;
            r = mon_off[id] % BIT;
            if ((r == 0 || r == BIT - 1) && line !== exp_bit(mon_exp[id], k)) mon_bad[id] = 1'b1;
            if (r == BIT / 2 && k >= 1 && k <= 8) mon_got[id] = {mon_got[id][6:0], line};
            if (done !== ((mon_off[id] == flen - 1) ? 1'b1 : 1'b0)) mon_dbad[id] = 1'b1;
            mon_off[id]++;
            if (mon_off[id] == flen) begin
                chk($sformatf("frame_byte%0d", id), 32'(mon_got[id]), 32'(mon_exp[id]));
                chk($sformatf("frame_bit_edges%0d_%02h", id, mon_exp[id]), 32'(mon_bad[id]), 32'(0));
                chk($sformatf("done_timing%0d_%02h", id, mon_exp[id]), 32'(mon_dbad[id]), 32'(0));
                mon_act[id] = 1'b0;
            end
        end
        mon_prev[id] = line;
    endtask

    always @(negedge clk) mon_step(0, line0, done0, 1);
    always @(negedge clk) mon_step(1, line1, done1, 2);

    // Drive one byte from a negedge; returns the cycle number of the accepting rising edge
    task automatic push(input int id, input logic [7:0] b, output int acc);
        int g;
        g = 0;
        if (id == 0) begin u_if0.data = b; u_if0.valid = 1'b1; end
        else begin u_if1.data = b; u_if1.valid = 1'b1; end
        while (((id == 0) ? u_if0.ready : u_if1.ready) !== 1'b1 && g < GUARD) begin
            @(negedge clk);
            g++;
        end
        acc = -1;
        if (g >= GUARD) begin
            chk($sformatf("push_timeout%0d_%02h", id, b), 32'(0), 32'(1));
        end else begin
            @(negedge clk);
            acc = cyc;
            if (id == 0) q0.push_back(b); else q1.push_back(b);
        end
        if (id == 0) u_if0.valid = 1'b0; else u_if1.valid = 1'b0;
    endtask

    task automatic do_reset0(input string tag);
        #2;
        rst_n0 = 1'b0;
        #1;
        chk({tag, "_line"},  32'(line0),       32'(1));
        chk({tag, "_count"}, 32'(cnt0),        32'(0));
        chk({tag, "_ready"}, 32'(u_if0.ready), 32'(1));
        chk({tag, "_busy"},  32'(busy0),       32'(0));
        chk({tag, "_done"},  32'(done0),       32'(0));
        q0.delete();
        mon_act[0]  = 1'b0;
        mon_prev[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n0 = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: still running at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        fork
            begin : t0
                int acc, t, s0, g, old;
                bit bad;
                u_if0.valid = 1'b0;
                u_if0.data  = 8'h00;
                rst_n0      = 1'b0;
                repeat (3) @(negedge clk);
                chk("rst_line",  32'(line0),       32'(1));
                chk("rst_ready", 32'(u_if0.ready), 32'(1));
                chk("rst_busy",  32'(busy0),       32'(0));
                chk("rst_done",  32'(done0),       32'(0));
                chk("rst_count", 32'(cnt0),        32'(0));
                rst_n0 = 1'b1;
                repeat (2) @(negedge clk);

                // 0xA5 into an empty idle FIFO, then 0x00/0xFF/0x3C queued behind it
                push(0, 8'hA5, acc);
                chk("cnt_after_a5", 32'(cnt0), 32'(1));
                chk("line_idle_at_accept", 32'(line0), 32'(1));
                @(negedge clk);
                chk("line_idle_accept_plus1", 32'(line0), 32'(1));
                chk("busy_after_start", 32'(busy0), 32'(1));
                chk("cnt_after_pop_a5", 32'(cnt0), 32'(0));
                @(negedge clk);
                chk("start_latency_2", 32'(line0), 32'(0));
                s0 = acc + 2;
                push(0, 8'h00, t);
                chk("cnt_seq_1", 32'(cnt0), 32'(1));
                push(0, 8'hFF, t);
                chk("cnt_seq_2", 32'(cnt0), 32'(2));
                push(0, 8'h3C, t);
                chk("cnt_seq_3", 32'(cnt0), 32'(3));
                for (int n = 0; n < 3; n++) begin
                    old = 3 - n;
                    g = 0;
                    while (int'(cnt0) == old && g < GUARD) begin @(negedge clk); g++; end
                    chk($sformatf("pop_count_%0d", n), 32'(cnt0), 32'(old - 1));
                    chk($sformatf("pop_cycle_%0d", n), cyc, s0 + (n + 1) * FRM1 - 1);
                end
                g = 0;
                while ((busy0 !== 1'b0 || mon_act[0]) && g < GUARD) begin @(negedge clk); g++; end
                chk("drain0_in_time", 32'(g < GUARD), 32'(1));
                chk("frames_seen_4", starts0.size(), 32'(4));
                chk("first_start_cycle", starts0[0], s0);
                for (int i = 0; i < 3; i++)
                    chk($sformatf("back_to_back_gap_%0d", i), starts0[i + 1] - starts0[i], FRM1);

                // Fill to 16 behind a running frame; one more byte must wait for the next pop
                starts0.delete();
                push(0, 8'h11, acc);
                s0 = acc + 2;
                push(0, 8'h20, t);
                chk("simul_push_pop_count", 32'(cnt0), 32'(1));
                for (int i = 1; i < 16; i++) push(0, 8'(8'h20 + i), t);
                chk("full_count", 32'(cnt0), 32'(16));
                chk("ready_low_when_full", 32'(u_if0.ready), 32'(0));
                push(0, 8'h5A, t);
                chk("held_byte_accept_cycle", t, s0 + FRM1);
                chk("count_after_held", 32'(cnt0), 32'(16));
                do_reset0("rst_full");

                // Reset inside the fifth data slot of 0x55 (line low there) with three bytes queued
                push(0, 8'h55, acc);
                s0 = acc + 2;
                push(0, 8'h01, t);
                push(0, 8'h02, t);
                push(0, 8'h03, t);
                chk("queued_three", 32'(cnt0), 32'(3));
                g = 0;
                while (cyc < s0 + 5 * BIT + BIT / 2 && g < GUARD) begin @(negedge clk); g++; end
                chk("line_low_before_reset", 32'(line0), 32'(0));
                do_reset0("rst_mid");
                bad = 1'b0;
                repeat (2 * BIT) begin
                    @(negedge clk);
                    if (line0 !== 1'b1) bad = 1'b1;
                end
                chk("no_frame_after_reset", 32'(bad), 32'(0));
                chk("count_zero_after_reset", 32'(cnt0), 32'(0));
                chk("busy_zero_after_reset", 32'(busy0), 32'(0));
            end
            begin : t1
                int acc, t, g;
                u_if1.valid = 1'b0;
                u_if1.data  = 8'h00;
                rst_n1      = 1'b0;
                repeat (3) @(negedge clk);
                chk("sb2_rst_line",  32'(line1), 32'(1));
                chk("sb2_rst_count", 32'(cnt1),  32'(0));
                rst_n1 = 1'b1;
                repeat (2) @(negedge clk);
                push(1, 8'h81, acc);
                push(1, 8'h7E, t);
                chk("sb2_simul_push_pop", 32'(cnt1), 32'(1));
                g = 0;
                while ((starts1.size() < 2 || mon_act[1] || busy1 !== 1'b0) && g < 4 * GUARD) begin
                    @(negedge clk);
                    g++;
                end
                chk("sb2_drain_in_time", 32'(g < 4 * GUARD), 32'(1));
                chk("sb2_first_start", starts1[0], acc + 2);
                chk("sb2_frame_len", starts1[1] - starts1[0], FRM2);
            end
        join
        chk("q0_all_frames_seen", q0.size(), 32'(0));
        chk("q1_all_frames_seen", q1.size(), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
